// File: rtl/sector_uart_streamer_if.sv
// rtl/sector_uart_streamer_if.sv - SD block write, UART rx/tx and status signals of the sector streamer
interface sector_uart_streamer_if #(
    parameter int ADDR_W = 9
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              blk_done;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              tx_busy;
    logic [7:0]        tx_data;
    logic              tx_stb;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output wr_en, wr_addr, wr_data, blk_done, rx_data, rx_valid, tx_busy,
        input  tx_data, tx_stb, busy, done, overrun
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, blk_done, rx_data, rx_valid, tx_busy,
        output tx_data, tx_stb, busy, done, overrun
    );
endinterface

// File: rtl/sector_uart_streamer.sv
// rtl/sector_uart_streamer.sv - buffers one SD block and streams it to the UART; SECTOR_HEX_EN selects ASCII-hex dump
module sector_uart_streamer #(
    parameter int BLOCK_BYTES = 512,
    parameter int ADDR_W      = 9,
    parameter int LINE_BYTES  = 16
) (
    input logic                   clk,
    input logic                   rst,
    sector_uart_streamer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_HOLD, S_WAIT} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLOCK_BYTES - 1);

    if ((1 << ADDR_W) != BLOCK_BYTES || BLOCK_BYTES < 4 || LINE_BYTES < 1 ||
        LINE_BYTES > BLOCK_BYTES || (LINE_BYTES & (LINE_BYTES - 1)) != 0) begin : g_cfg_check
        $error("sector_uart_streamer: inconsistent BLOCK_BYTES/ADDR_W/LINE_BYTES");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              overrun_q, overrun_d;
    logic              done_q, done_d;
    logic [7:0]        rd_data_q;
    logic [7:0]        mem [BLOCK_BYTES];

    logic              busy_w;
    logic              start_w;
    logic              stb_w;
    logic              rd_en_w;
    logic              byte_done_w;
    logic [7:0]        char_w;

    assign busy_w  = (state_q != S_IDLE);
    // A simultaneous blk_done and 'R' collapse into this single start condition.
    assign start_w = !busy_w && (bus.blk_done || (bus.rx_valid && bus.rx_data == 8'h52));
    assign stb_w   = (state_q == S_SEND) && !bus.tx_busy;

    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy_w) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en_w) begin
            rd_data_q <= mem[idx_q];
        end
    end

`ifdef SECTOR_HEX_EN
    typedef enum logic [1:0] {C_HI, C_LO, C_CR, C_LF} csel_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

    csel_t      csel_q, csel_d;
    csel_t      csel_next_w;
    logic [3:0] nib_w;
    logic       line_end_w;

    assign nib_w       = (csel_q == C_HI) ? rd_data_q[7:4] : rd_data_q[3:0];
    assign line_end_w  = (idx_q & LINE_MASK) == LINE_MASK;
    // The byte is finished after its low nibble, unless a CR/LF pair closes the line.
    assign byte_done_w = (csel_q == C_LF) || ((csel_q == C_LO) && !line_end_w);
    assign csel_next_w = (csel_q == C_HI) ? C_LO : ((csel_q == C_LO) ? C_CR : C_LF);

    always_comb begin
        case (csel_q)
            C_CR:    char_w = 8'h0D;
            C_LF:    char_w = 8'h0A;
            default: char_w = (nib_w < 4'd10) ? (8'h30 + {4'h0, nib_w})
                                              : (8'h37 + {4'h0, nib_w});
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csel_q <= C_HI;
        end else begin
            csel_q <= csel_d;
        end
    end
`else
    assign byte_done_w = 1'b1;
    assign char_w      = rd_data_q;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        rd_en_w   = 1'b0;
`ifdef SECTOR_HEX_EN
        csel_d    = csel_q;
`endif
        if (start_w) begin
            overrun_d = 1'b0;
        end else if (busy_w && (bus.wr_en || bus.blk_done)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
`ifdef SECTOR_HEX_EN
                    csel_d  = C_HI;
`endif
                end
            end
            S_FETCH: begin
                rd_en_w = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (stb_w) begin
                    state_d = S_HOLD;
                end
            end
            // The UART only raises busy the cycle after the strobe, so skip one look.
            S_HOLD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.tx_busy) begin
                    if (!byte_done_w) begin
                        state_d = S_SEND;
`ifdef SECTOR_HEX_EN
                        csel_d  = csel_next_w;
`endif
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        idx_d   = idx_q + 1'b1;
`ifdef SECTOR_HEX_EN
                        csel_d  = C_HI;
`endif
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    assign bus.tx_stb  = stb_w;
    assign bus.tx_data = busy_w ? char_w : 8'h00;
    assign bus.busy    = busy_w;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_sector_uart_streamer.sv
// tb/tb_sector_uart_streamer.sv - randomized bench with a character-queue model of sector_uart_streamer
module tb_sector_uart_streamer;
    localparam int BB = 4;
    localparam int AW = 2;
    localparam int LB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sector_uart_streamer_if #(.ADDR_W(AW)) bus ();

    sector_uart_streamer #(.BLOCK_BYTES(BB), .ADDR_W(AW), .LINE_BYTES(LB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ch;
        logic       fetch;
    } exp_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    exp_t       expq[$];
    logic [7:0] log_q[$];
    logic [7:0] lit[$];
    logic [7:0] mem_m [BB];
    bit         active = 0;
    bit         bp = 0;
    bit         ovr_m = 0;
    int         start_cyc = 0;
    int         last_stb = 0;
    int         done_cyc_exp = -1;
    int         n_stb = 0;
    int         done_cnt = 0;
    logic [7:0] last_ch = 8'h00;
    int         uart_t = 10;
    bit         hold = 0;
    int         ucnt = 0;
    logic       stb_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    task automatic build_expect();
        expq.delete();
        for (int i = 0; i < BB; i++) begin
`ifdef SECTOR_HEX_EN
            expq.push_back('{hexc(mem_m[i][7:4]), 1'b1});
            expq.push_back('{hexc(mem_m[i][3:0]), 1'b0});
            if ((i + 1) % LB == 0) begin
                expq.push_back('{8'h0D, 1'b0});
                expq.push_back('{8'h0A, 1'b0});
            end
`else
            expq.push_back('{mem_m[i], 1'b1});
`endif
        end
    endtask

    function automatic bit busy_exp(input int c);
        return active && (c > start_cyc) && !(done_cyc_exp >= 0 && c >= done_cyc_exp);
    endfunction

    // Ideal UART: busy for uart_t cycles after each strobe, optionally stretched by hold.
    always @(negedge clk) stb_seen = bus.tx_stb;
    always @(posedge clk) begin
        #1;
        if (rst) ucnt = 0;
        else if (stb_seen) ucnt = uart_t;
        else if (ucnt > 0) ucnt--;
        bus.tx_busy = (ucnt > 0) || hold;
    end

    always @(negedge clk) begin
        int   c;
        bit   be;
        exp_t e;
        if (!rst) begin
            c  = cyc;
            be = busy_exp(c);
            chk("busy", bus.busy, be);
            chk("done", bus.done, active && (c == done_cyc_exp));
            chk("overrun", bus.overrun, ovr_m);
            if (bus.done) done_cnt++;
            if (bus.tx_stb) begin
                chk("stb_while_tx_busy", bus.tx_busy, 0);
                if (!be || expq.size() == 0) begin
                    chk("unexpected_stb", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("tx_data", bus.tx_data, e.ch);
                    if (!bp) begin
                        if (n_stb == 0) chk("first_stb_latency", c - start_cyc, 2);
                        else chk("stb_spacing", c - last_stb, e.fetch ? uart_t + 3 : uart_t + 2);
                    end
                    log_q.push_back(bus.tx_data);
                    last_ch  = bus.tx_data;
                    last_stb = c;
                    n_stb++;
                end
            end else if (be && n_stb > 0 && bus.tx_busy) begin
                chk("tx_data_stable", bus.tx_data, last_ch);
            end
            if (active && expq.size() == 0 && n_stb > 0 && done_cyc_exp < 0 &&
                c >= last_stb + 2 && !bus.tx_busy) begin
                done_cyc_exp = c + 1;
            end
            if (active && c == done_cyc_exp) active = 0;
            if (bus.wr_en && !be) mem_m[bus.wr_addr] = bus.wr_data;
            if (!be && (bus.blk_done || (bus.rx_valid && bus.rx_data == 8'h52))) begin
                active       = 1;
                start_cyc    = c;
                done_cyc_exp = -1;
                n_stb        = 0;
                ovr_m        = 0;
                bp           = 0;
                build_expect();
            end else if (be && (bus.wr_en || bus.blk_done)) begin
                ovr_m = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [AW-1:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_blk();
        bus.blk_done = 1'b1;
        step();
        bus.blk_done = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d);
        bus.rx_valid = 1'b1; bus.rx_data = d;
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit noise);
        int r;
        for (int k = 0; k < 4000 && active; k++) begin
            if (noise) begin
                r = $urandom_range(0, 31);
                if (r < 4) begin
                    bus.rx_valid = 1'b1;
                    bus.rx_data  = (r == 0) ? 8'h52 : 8'($urandom_range(0, 255));
                end else if (r == 4) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = AW'($urandom_range(0, BB - 1));
                    bus.wr_data = 8'($urandom_range(0, 255));
                end else if (r == 5) begin
                    bus.blk_done = 1'b1;
                end
            end
            step();
            bus.rx_valid = 1'b0; bus.wr_en = 1'b0; bus.blk_done = 1'b0;
        end
        chk("idle_timeout", active, 0);
    endtask

    task automatic wait_stb(input int n);
        for (int k = 0; k < 2000 && n_stb < n; k++) step();
        chk("stb_timeout", n_stb >= n, 1);
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_len"}, log_q.size(), lit.size());
        for (int i = 0; i < lit.size() && i < log_q.size(); i++) chk(nm, log_q[i], lit[i]);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 8'h00; bus.blk_done = 1'b0;
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_busy = 1'b0;
        for (int i = 0; i < BB; i++) mem_m[i] = 8'h00;
        repeat (3) step();
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_tx_stb", bus.tx_stb, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_overrun", bus.overrun, 0);
        rst = 1'b0;
        step();

`ifdef SECTOR_HEX_EN
        write_byte(0, 8'hA5); write_byte(1, 8'h0F); write_byte(2, 8'h00); write_byte(3, 8'h9C);
        lit = '{8'h41, 8'h35, 8'h30, 8'h46, 8'h0D, 8'h0A, 8'h30, 8'h30, 8'h39, 8'h43, 8'h0D, 8'h0A};
`else
        write_byte(0, 8'h11); write_byte(1, 8'h22); write_byte(2, 8'h33); write_byte(3, 8'h44);
        lit = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
        uart_t = 10;
        log_q.delete(); done_cnt = 0;
        pulse_blk();
        wait_idle(0);
        check_log("first_stream");
        chk("first_done_pulses", done_cnt, 1);
        chk("first_overrun", bus.overrun, 0);

        log_q.delete();
        send_rx(8'h52);
        wait_idle(0);
        check_log("replay");

        log_q.delete();
        send_rx(8'h41);
        repeat (20) step();
        chk("non_r_no_activity", log_q.size(), 0);

        send_rx(8'h52);
        wait_stb(1);
        write_byte(0, 8'hFF);
        wait_idle(0);
        chk("overrun_sticky", bus.overrun, 1);
        log_q.delete();
        send_rx(8'h52);
        chk("start_clears_overrun", bus.overrun, 0);
        wait_idle(0);
        check_log("replay_after_drop");

        pulse_blk();
        wait_stb(1);
        hold = 1; bp = 1;
        repeat (50) step();
        chk("backpressure_no_stb", n_stb, 1);
        hold = 0;
        wait_idle(0);

        uart_t = 4;
        pulse_blk();
        wait_stb(1);
        write_byte(1, 8'hEE);
        wait_stb(2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tx_data", bus.tx_data, 8'h00);
        chk("midrst_tx_stb", bus.tx_stb, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_overrun", bus.overrun, 0);
        active = 0; expq.delete(); ovr_m = 0; done_cyc_exp = -1;
        step();
        rst = 1'b0;
        step();
        log_q.delete();
        pulse_blk();
        wait_idle(0);
        check_log("restart_after_rst");

        for (int round = 0; round < 15; round++) begin
            uart_t = $urandom_range(1, 12);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < BB; i++) write_byte(AW'(i), 8'($urandom_range(0, 255)));
            end
            case ($urandom_range(0, 2))
                0: bus.blk_done = 1'b1;
                1: begin bus.rx_valid = 1'b1; bus.rx_data = 8'h52; end
                default: begin bus.blk_done = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h52; end
            endcase
            step();
            bus.blk_done = 1'b0; bus.rx_valid = 1'b0;
            wait_idle(1);
            repeat ($urandom_range(0, 5)) step();
        end

        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
